// File: rtl/deserializer.sv
// Serial-to-parallel converter: gathers WIDTH qualified bits into a word and
// presents it with a one-cycle valid strobe for the downstream priority encoder.
module deserializer #(
   parameter int WIDTH     = 5,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             data_i,
   input  logic             data_val_i,
   output logic [WIDTH-1:0] deser_data_o,
   output logic             deser_data_val_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             val_q, val_d;
   logic [WIDTH-1:0] shifted;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {shreg_q[WIDTH-2:0], data_i};
      end else begin : g_lsb_first
         assign shifted = {data_i, shreg_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      shreg_d = shreg_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      val_d   = 1'b0;
      if (data_val_i) begin
         shreg_d = shifted;
         // The word-completing bit goes straight into the output register.
         if (cnt_q == LAST_CNT) begin
            data_d = shifted;
            val_d  = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         shreg_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         val_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_val_o = val_q;
   assign busy_o           = (cnt_q != '0);

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: an MSB-first and an LSB-first instance share
// one serial stream; expected words are hand-computed for each bit order.
module tb_deserializer;

   logic       clk = 1'b0;
   logic       arstn = 1'b0;
   logic       data = 1'b0;
   logic       data_val = 1'b0;
   logic [4:0] m_data, l_data;
   logic       m_val, l_val, m_busy, l_busy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   deserializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u_msb (
      .clk_i(clk), .arstn_i(arstn), .data_i(data), .data_val_i(data_val),
      .deser_data_o(m_data), .deser_data_val_o(m_val), .busy_o(m_busy)
   );

   deserializer #(.WIDTH(5), .MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk), .arstn_i(arstn), .data_i(data), .data_val_i(data_val),
      .deser_data_o(l_data), .deser_data_val_o(l_val), .busy_o(l_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Drive one accepted bit at a falling edge; return at the next falling edge.
   task automatic send_bit(input logic b);
      data     = b;
      data_val = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         data = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " m_data"}, 32'(m_data), 32'h0);
      check({tag, " m_val"},  32'(m_val),  32'h0);
      check({tag, " m_busy"}, 32'(m_busy), 32'h0);
      check({tag, " l_data"}, 32'(l_data), 32'h0);
      check({tag, " l_val"},  32'(l_val),  32'h0);
      check({tag, " l_busy"}, 32'(l_busy), 32'h0);
   endtask

   logic [4:0] bits_a, words_m [4], words_l [4], stream_w;
   int strobes;

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      arstn = 1'b1;
      @(negedge clk);

      // Load a nonzero word and a partial word, then reset between edges.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check("prefill m_data", 32'(m_data), 32'h1f);
      send_bit(1'b1);
      send_bit(1'b0);
      check("prefill busy", 32'(m_busy), 32'h1);
      #2 arstn = 1'b0;
      #1 check_all_zero("async reset");
      @(negedge clk);
      arstn = 1'b1;

      // MSB/LSB word: bits 1,0,1,1,0.
      bits_a = 5'b10110;
      for (int i = 0; i < 5; i++) begin
         send_bit(bits_a[4-i]);
         check($sformatf("word1 busy b%0d", i), 32'(m_busy), (i < 4) ? 32'h1 : 32'h0);
         check($sformatf("word1 val b%0d", i), 32'(m_val), (i == 4) ? 32'h1 : 32'h0);
      end
      check("word1 m_data", 32'(m_data), 32'h16);
      check("word1 l_data", 32'(l_data), 32'h0d);
      check("word1 l_val", 32'(l_val), 32'h1);
      idle(1);
      check("word1 strobe drop", 32'(m_val), 32'h0);
      check("word1 l strobe drop", 32'(l_val), 32'h0);

      // Gaps: bits 0,0,0,0,1 with 3 idle cycles (random data) between bits.
      strobes = 0;
      bits_a = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         send_bit(bits_a[4-i]);
         if (m_val) strobes++;
         if (i < 4) begin
            for (int k = 0; k < 3; k++) begin
               idle(1);
               if (m_val) strobes++;
            end
         end
      end
      check("gap m_data", 32'(m_data), 32'h01);
      check("gap l_data", 32'(l_data), 32'h10);
      for (int k = 0; k < 22; k++) begin
         idle(1);
         if (m_val) strobes++;
         check($sformatf("gap hold c%0d", k), 32'(m_data), 32'h01);
      end
      check("gap strobe count", 32'(strobes), 32'h1);

      // Back-to-back: 20 continuous bits.
      words_m = '{5'b11111, 5'b00000, 5'b10000, 5'b00001};
      words_l = '{5'b11111, 5'b00000, 5'b00001, 5'b10000};
      for (int w = 0; w < 4; w++) begin
         stream_w = words_m[w];
         for (int i = 0; i < 5; i++) begin
            send_bit(stream_w[4-i]);
            check($sformatf("b2b val w%0d b%0d", w, i), 32'(m_val), (i == 4) ? 32'h1 : 32'h0);
         end
         check($sformatf("b2b m_data w%0d", w), 32'(m_data), 32'(words_m[w]));
         check($sformatf("b2b l_data w%0d", w), 32'(l_data), 32'(words_l[w]));
      end

      // Reset mid-word: 1,1,1 discarded, then 0,0,0,1,0.
      idle(2);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      check("midword busy", 32'(m_busy), 32'h1);
      #2 arstn = 1'b0;
      #1 check("midword reset busy", 32'(m_busy), 32'h0);
      check("midword reset l_busy", 32'(l_busy), 32'h0);
      @(negedge clk);
      arstn = 1'b1;
      bits_a = 5'b00010;
      strobes = 0;
      for (int i = 0; i < 5; i++) begin
         send_bit(bits_a[4-i]);
         if (m_val) strobes++;
      end
      check("midword strobe count", 32'(strobes), 32'h1);
      check("midword m_val", 32'(m_val), 32'h1);
      check("midword m_data", 32'(m_data), 32'h02);
      check("midword l_data", 32'(l_data), 32'h08);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
